axi_sram_read_slave: RTL and testbench
======================================

Name: axi_sram_read_slave

Overview:
- AXI read-side slave endpoint. It accepts one AR request at a time, reads a single-port SRAM beat by beat, and returns R beats carrying the full slave-side ID.
- This is the block that drives the S0_/S1_ R-channel inputs of the interconnect's read-data router.
- One outstanding transaction only. Burst types FIXED, INCR and WRAP are supported with 32-bit beats.

Parameters:
- IDS_BITS, 8, slave-side ID width: {master index[7:4], master ID[3:0]}; returned unchanged on RID.
- ADDR_BITS, 32, AXI byte-address width.
- DATA_BITS, 32, beat width; the only legal ARSize is 3'b010.
- SRAM_AW, 14, SRAM word-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- ARID  in  IDS_BITS  request ID
- ARAddr  in  ADDR_BITS  start byte address
- ARLen  in  4  beats-1
- ARSize  in  3  beat size
- ARBurst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ARValid  in  1  request valid
- ARReady  out  1  request accepted
- RID  out  IDS_BITS  response ID
- RData  out  DATA_BITS  read data
- RResp  out  2  00 OKAY, 10 SLVERR
- RLast  out  1  final beat
- RValid  out  1  beat valid
- RReady  in  1  master ready
- sram_cs  out  1  SRAM read strobe
- sram_addr  out  SRAM_AW  word address = cur_addr[SRAM_AW+1:2]
- sram_do  in  DATA_BITS  SRAM read data, valid the cycle after sram_cs

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - ARReady=1 (asserted in IDLE). RValid=0, RLast=0, RID=0, RData=0, RResp=00, sram_cs=0, sram_addr=0.
  - Internal registers (ID, address, length, burst, beat count, error flag) clear.
  - A reset mid-burst drops the transaction. No further beats are issued.
- FSM states: IDLE, RD, CAP, VALID.
  - IDLE: ARReady=1. On ARValid&&ARReady, latch ARID, ARAddr, ARLen, ARBurst; set err=(ARSize!=3'b010); beat_cnt=0; go to RD.
  - RD: sram_cs=1, sram_addr from cur_addr; go to CAP. ARReady=0.
  - CAP: rdata_q<=sram_do; go to VALID.
  - VALID: RValid=1. RData=rdata_q, RID=latched ID, RResp=err?10:00, RLast=(beat_cnt==len).
    - RReady=0: hold all R outputs stable. No change to address or count.
    - RReady=1 and RLast=1: go to IDLE.
    - RReady=1 and RLast=0: beat_cnt+1, advance address, go to RD.
- ARReady is 0 in every state except IDLE. At most one outstanding request.
- Latency:
  - AR handshake at cycle N gives first RValid at N+3.
  - Each subsequent beat's RValid comes 3 cycles after the previous R handshake.
  - A transaction finishing in cycle M allows ARReady=1 at M+1.
- Address advance, on each non-last R handshake:
  - FIXED: address unchanged.
  - INCR: address+4, modulo 2^ADDR_BITS.
  - WRAP: legal only for len+1 in {2,4,8,16}.
    - wrap size W=(len+1)*4; base=addr & ~(W-1).
    - next = base | ((addr+4) & (W-1)).
  - WRAP with an illegal length, or burst=11: treated as INCR, and err is set (SLVERR on every beat).
- ARSize error: SLVERR on every beat. The beat count is still honoured and SRAM reads still occur.
- ARAddr[1:0] is ignored (treated as zero) for SRAM addressing.
- An ARValid seen while not in IDLE is not accepted. The master must hold it.

Test Plan:
- Single beat: ARID=8'h13, ARAddr=0x40, len=0, INCR, SRAM[16]=0xDEADBEEF, RReady=1.
  -> RValid at handshake+3, RData=0xDEADBEEF, RID=8'h13, RLast=1, RResp=00, ARReady back to 1 the next cycle.
- INCR len=3 from 0x100, RReady low for 4 cycles on beat 1.
  -> sram_addr sequence 0x40,0x41,0x42,0x43.
  -> beat 1 outputs held stable during the stall.
  -> RLast only on beat 3.
- WRAP len=3 from 0x18.
  -> byte addresses 0x18,0x1C,0x10,0x14, OKAY on every beat.
- FIXED len=2 at 0x20.
  -> three beats, all from sram_addr 0x08.
  -> burst=11, and WRAP len=2 (illegal length), both give SRAM reads as INCR with RResp=10 on every beat.
- ARSize=3'b001, len=1.
  -> two beats with RResp=10, RLast on the second beat.
- Reset mid-burst: rst=0 for one cycle during beat 2 of len=7.
  -> next cycle RValid=0, ARReady=1.
  -> a new request afterwards completes normally with correct RID and data.

Source files
------------

// File: rtl/axi_sram_read_slave.sv
// AXI read-only slave endpoint in front of a single-port SRAM.
// One outstanding AR at a time; FIXED/INCR/WRAP bursts of 32-bit beats, full slave-side ID echoed on RID.
module axi_sram_read_slave #(
    parameter int IDS_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int SRAM_AW   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDS_BITS-1:0]  ARID,
    input  logic [ADDR_BITS-1:0] ARAddr,
    input  logic [3:0]           ARLen,
    input  logic [2:0]           ARSize,
    input  logic [1:0]           ARBurst,
    input  logic                 ARValid,
    output logic                 ARReady,
    output logic [IDS_BITS-1:0]  RID,
    output logic [DATA_BITS-1:0] RData,
    output logic [1:0]           RResp,
    output logic                 RLast,
    output logic                 RValid,
    input  logic                 RReady,
    output logic                 sram_cs,
    output logic [SRAM_AW-1:0]   sram_addr,
    input  logic [DATA_BITS-1:0] sram_do
);

    typedef enum logic [1:0] {IDLE, RD, CAP, VALID} state_t;

    state_t                 state_q;
    logic [IDS_BITS-1:0]    id_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [3:0]             len_q;
    logic [1:0]             burst_q;
    logic [3:0]             cnt_q;
    logic                   err_q;
    logic                   arready_q;
    logic                   rvalid_q;
    logic                   rlast_q;
    logic [IDS_BITS-1:0]    rid_q;
    logic [DATA_BITS-1:0]   rdata_q;
    logic [1:0]             rresp_q;
    logic                   cs_q;
    logic [SRAM_AW-1:0]     saddr_q;

    logic [ADDR_BITS-1:0]   next_addr_d;
    logic [ADDR_BITS-1:0]   incr_addr_s;
    logic [ADDR_BITS-1:0]   wrap_mask_s;
    logic                   ar_err_s;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // Next-beat address and request error classification
    always_comb begin
        incr_addr_s = addr_q + ADDR_BITS'(4);
        // Wrap window minus one is (len+1)*4-1, i.e. {len, 2'b11}
        wrap_mask_s = {{(ADDR_BITS-6){1'b0}}, len_q, 2'b11};
        next_addr_d = incr_addr_s;
        case (burst_q)
            2'b00:   next_addr_d = addr_q;
            2'b10: begin
                if (wrap_len_ok(len_q)) begin
                    next_addr_d = (addr_q & ~wrap_mask_s) | (incr_addr_s & wrap_mask_s);
                end else begin
                    next_addr_d = incr_addr_s;
                end
            end
            default: next_addr_d = incr_addr_s;
        endcase
        ar_err_s = (ARSize != 3'b010) || (ARBurst == 2'b11) ||
                   ((ARBurst == 2'b10) && !wrap_len_ok(ARLen));
    end

    // Transaction FSM with registered AR/R/SRAM outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 4'd0;
            burst_q   <= 2'b00;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            cs_q      <= 1'b0;
            saddr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARValid && arready_q) begin
                        id_q      <= ARID;
                        addr_q    <= ARAddr;
                        len_q     <= ARLen;
                        burst_q   <= ARBurst;
                        err_q     <= ar_err_s;
                        cnt_q     <= 4'd0;
                        arready_q <= 1'b0;
                        cs_q      <= 1'b1;
                        saddr_q   <= ARAddr[SRAM_AW+1:2];
                        state_q   <= RD;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RD: begin
                    cs_q    <= 1'b0;
                    state_q <= CAP;
                end
                CAP: begin
                    rdata_q  <= sram_do;
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rresp_q  <= err_q ? 2'b10 : 2'b00;
                    rlast_q  <= (cnt_q == len_q);
                    state_q  <= VALID;
                end
                VALID: begin
                    if (RReady) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 4'd1;
                            addr_q  <= next_addr_d;
                            saddr_q <= next_addr_d[SRAM_AW+1:2];
                            cs_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rlast_q   <= 1'b0;
                    cs_q      <= 1'b0;
                end
            endcase
        end
    end

    assign ARReady   = arready_q;
    assign RID       = rid_q;
    assign RData     = rdata_q;
    assign RResp     = rresp_q;
    assign RLast     = rlast_q;
    assign RValid    = rvalid_q;
    assign sram_cs   = cs_q;
    assign sram_addr = saddr_q;

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Bench for axi_sram_read_slave: directed table of bursts, mid-burst reset, then random bursts
// checked cycle by cycle against a burst-address model and a behavioural SRAM.
module tb_axi_sram_read_slave;

    logic        clk;
    logic        rst;
    logic [7:0]  ARID;
    logic [31:0] ARAddr;
    logic [3:0]  ARLen;
    logic [2:0]  ARSize;
    logic [1:0]  ARBurst;
    logic        ARValid;
    logic        ARReady;
    logic [7:0]  RID;
    logic [31:0] RData;
    logic [1:0]  RResp;
    logic        RLast;
    logic        RValid;
    logic        RReady;
    logic        sram_cs;
    logic [13:0] sram_addr;
    logic [31:0] sram_do;

    logic [31:0] mem [0:16383];
    int checks;
    int errors;

    axi_sram_read_slave dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARAddr(ARAddr), .ARLen(ARLen), .ARSize(ARSize),
        .ARBurst(ARBurst), .ARValid(ARValid), .ARReady(ARReady),
        .RID(RID), .RData(RData), .RResp(RResp), .RLast(RLast),
        .RValid(RValid), .RReady(RReady),
        .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_do(sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (sram_cs) sram_do <= mem[sram_addr];
    end

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          stall_beat;
        int          stall_cyc;
        logic [1:0]  exp_resp;
        logic [13:0] exp_last_word;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic model_wrap_ok(input logic [3:0] len);
        int n;
        n = int'(len) + 1;
        return (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    function automatic logic [1:0] model_resp(input logic [3:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        if (size != 3'd2 || burst == 2'd3 || (burst == 2'd2 && !model_wrap_ok(len))) return 2'b10;
        return 2'b00;
    endfunction

    // Byte address of beat i, from the burst rules directly
    function automatic logic [31:0] model_addr(input logic [31:0] a0, input logic [3:0] len,
                                               input logic [1:0] burst, input int i);
        logic [31:0] a, w, base;
        a = {a0[31:2], 2'b00};
        if (burst == 2'd0) return a;
        if (burst == 2'd2 && model_wrap_ok(len)) begin
            w    = (32'(len) + 32'd1) * 32'd4;
            base = a - (a % w);
            return base + ((a - base + 32'(i) * 32'd4) % w);
        end
        return a + 32'(i) * 32'd4;
    endfunction

    task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                           input int stall_beat, input int stall_cyc, input int abort_beat,
                           output logic [13:0] last_word);
        logic [31:0] ba;
        logic [13:0] w;
        logic [31:0] d;
        last_word = 14'd0;
        ARID = id; ARAddr = addr; ARLen = len; ARSize = size; ARBurst = burst; ARValid = 1'b1;
        chk("arready_idle", 64'(ARReady), 64'd1);
        @(posedge clk); #1;
        ARValid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            ba = model_addr(addr, len, burst, b);
            w  = ba[15:2];
            chk("rd_cs", 64'(sram_cs), 64'd1);
            chk("rd_addr", 64'(sram_addr), 64'(w));
            chk("rd_arready", 64'(ARReady), 64'd0);
            chk("rd_rvalid", 64'(RValid), 64'd0);
            last_word = sram_addr;
            d = mem[w];
            @(posedge clk); #1;
            chk("cap_rvalid", 64'(RValid), 64'd0);
            if (b == stall_beat && stall_cyc > 0) RReady = 1'b0;
            @(posedge clk); #1;
            chk("v_rvalid", 64'(RValid), 64'd1);
            chk("v_rdata", 64'(RData), 64'(d));
            chk("v_rid", 64'(RID), 64'(id));
            chk("v_rresp", 64'(RResp), 64'(exp_resp));
            chk("v_rlast", 64'(RLast), 64'(b == int'(len)));
            if (b == abort_beat) begin
                rst = 1'b0;
                @(posedge clk); #1;
                chk("abort_rvalid", 64'(RValid), 64'd0);
                chk("abort_arready", 64'(ARReady), 64'd1);
                chk("abort_cs", 64'(sram_cs), 64'd0);
                rst = 1'b1;
                @(posedge clk); #1;
                chk("abort_quiet", 64'({RValid, sram_cs}), 64'd0);
                return;
            end
            if (b == stall_beat) begin
                for (int s = 1; s < stall_cyc; s++) begin
                    @(posedge clk); #1;
                    chk("stall_hold", {RValid, RLast, RResp, RID, RData, sram_cs},
                        {1'b1, 1'(b == int'(len)), exp_resp, id, d, 1'b0});
                end
            end
            RReady = 1'b1;
            @(posedge clk); #1;
        end
        chk("done_arready", 64'(ARReady), 64'd1);
        chk("done_rvalid", 64'(RValid), 64'd0);
        chk("done_rlast", 64'(RLast), 64'd0);
    endtask

    initial begin
        logic [13:0] lw;
        logic [31:0] ra;
        logic [3:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;
        int          sb;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16384; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        mem[16] = 32'hDEADBEEF;

        vecs[0] = '{8'h13, 32'h0000_0040, 4'd0, 3'd2, 2'd1, 0, 0, 2'b00, 14'h010};
        vecs[1] = '{8'h21, 32'h0000_0100, 4'd3, 3'd2, 2'd1, 1, 4, 2'b00, 14'h043};
        vecs[2] = '{8'h35, 32'h0000_0018, 4'd3, 3'd2, 2'd2, 0, 0, 2'b00, 14'h005};
        vecs[3] = '{8'h47, 32'h0000_0020, 4'd2, 3'd2, 2'd0, 2, 2, 2'b00, 14'h008};
        vecs[4] = '{8'h5A, 32'h0000_0200, 4'd1, 3'd2, 2'd3, 0, 0, 2'b10, 14'h081};
        vecs[5] = '{8'h6B, 32'h0000_0300, 4'd2, 3'd2, 2'd2, 0, 0, 2'b10, 14'h0C2};
        vecs[6] = '{8'h7C, 32'h0000_0040, 4'd1, 3'd1, 2'd1, 1, 1, 2'b10, 14'h011};

        rst = 1'b0; ARValid = 1'b0; ARID = 8'h00; ARAddr = 32'h0; ARLen = 4'd0;
        ARSize = 3'd2; ARBurst = 2'd1; RReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(ARReady), 64'd1);
        chk("rst_outs", {RValid, RLast, RID, RData, RResp, sram_cs, sram_addr}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                    vecs[v].exp_resp, vecs[v].stall_beat, vecs[v].stall_cyc, -1, lw);
            chk("last_word", 64'(lw), 64'(vecs[v].exp_last_word));
        end
        chk("single_data", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);

        run_txn(8'h9A, 32'h0000_0400, 4'd7, 3'd2, 2'd1, 2'b00, -1, 0, 2, lw);
        run_txn(8'hA5, 32'h0000_0040, 4'd0, 3'd2, 2'd1, 2'b00, -1, 0, -1, lw);
        chk("recover_data", 64'(RData), 64'h0000_0000_DEAD_BEEF);
        chk("recover_id", 64'(RID), 64'hA5);

        for (int t = 0; t < 30; t++) begin
            ra = $urandom;
            rl = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            rb = 2'($urandom_range(0, 3));
            sb = $urandom_range(0, int'(rl));
            run_txn(8'($urandom), ra, rl, rs, rb, model_resp(rl, rs, rb), sb,
                    $urandom_range(0, 3), -1, lw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
